// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response
// channel and the decoder-facing instruction handshake.
interface ifu_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, op, funct3, funct7
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, op, funct3, funct7
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at a time,
// holds it for the decoder, and squashes in-flight responses on redirect.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        vld_q, vld_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // DROP means a granted request is still owed a response that must be thrown away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (bus.imem_gnt) state_d = bus.redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid)         state_d = bus.redirect_valid ? S_REQ : S_HOLD;
        else if (bus.redirect_valid) state_d = S_DROP;
      end
      S_HOLD:  if (bus.redirect_valid || bus.inst_ready) state_d = S_REQ;
      S_DROP:  if (bus.imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    vld_d     = vld_q;
    if (state_q == S_WAIT && bus.imem_rvalid && !bus.redirect_valid) begin
      inst_d    = bus.imem_rdata;
      inst_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;
      vld_d     = 1'b1;
    end
    if (state_q == S_HOLD && (bus.redirect_valid || bus.inst_ready)) vld_d = 1'b0;
    if (bus.redirect_valid) pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      vld_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      vld_q     <= vld_d;
    end
  end

  // Request is masked while reset is held so nothing is issued during reset.
  always_comb begin
    bus.imem_req   = (state_q == S_REQ) && !rst;
    bus.imem_addr  = pc_q;
    bus.inst_valid = vld_q;
    bus.inst       = inst_q;
    bus.inst_pc    = inst_pc_q;
    bus.op         = inst_q[6:0];
    bus.funct3     = inst_q[14:12];
    bus.funct7     = inst_q[31:25];
  end

endmodule
